ram_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port synchronous RAM between NREQ requesters.
- The RAM has a registered read address and a registered output, giving 2-cycle internal read latency.
- The block accepts at most one command per cycle, registers it onto the RAM port, and returns read data to the originating requester with a fixed latency.
- It sits between the client engines and the RAM instance; the RAM is instantiated alongside it, not inside it.

---
 rtl/ram_port_arbiter_if.sv | 43 ++++
 rtl/ram_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester-side bus of the RAM port arbiter.
// Packs every requester's command (req/we/addr/wdata) into flat vectors and
// carries the grant and read-return signals back. The master modport is the
// client-engine side, the slave modport is the arbiter side.
// Optional feature macro: ARB_LOCK_EN (adds the per-requester req_lock vector).
interface ram_port_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int NREQ  = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_we;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_wdata;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]       req_lock;
`endif
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rvalid;
  logic [WIDTH-1:0]      rdata;

`ifdef ARB_LOCK_EN
  modport master (
    output req, req_we, req_addr, req_wdata, req_lock,
    input  gnt, rvalid, rdata
  );
  modport slave (
    input  req, req_we, req_addr, req_wdata, req_lock,
    output gnt, rvalid, rdata
  );
`else
  modport master (
    output req, req_we, req_addr, req_wdata,
    input  gnt, rvalid, rdata
  );
  modport slave (
    input  req, req_we, req_addr, req_wdata,
    output gnt, rvalid, rdata
  );
`endif
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one single-port synchronous
// RAM (registered address + registered output) between NREQ requesters.
// One command per cycle is granted combinationally, registered onto the RAM
// port, and read data is returned to the originating requester exactly three
// cycles after its grant, tagged through a short valid/id pipeline.
// Optional feature macro: ARB_LOCK_EN -- adds bus.req_lock; a locked winner
// keeps priority for up to LOCK_MAX consecutive grants.
module ram_port_arbiter #(
  parameter int  WIDTH    = 8,
  parameter int  DEPTH    = 64,
  parameter int  NREQ     = 4,
  parameter int  LOCK_MAX = 8,
  localparam int AW       = $clog2(DEPTH),
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_port_arbiter_if.slave bus,
  output logic              ram_we_o,
  output logic [AW-1:0]     ram_addr_o,
  output logic [WIDTH-1:0]  ram_data_o,
  input  logic [WIDTH-1:0]  ram_q_i
);

  // Reject configurations the arbiter was never meant to handle.
  generate
    if (NREQ < 2 || NREQ > 8 || LOCK_MAX < 1) begin : g_param_check
      $error("ram_port_arbiter: NREQ must be 2..8 and LOCK_MAX >= 1");
    end
  endgenerate

  // Round-robin pointer: the requester searched first.
  logic [IDW-1:0]   ptr_q, ptr_d;

  // Arbitration results for the current cycle.
  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   win_inc;
  logic             grant_v;
  logic [NREQ-1:0]  gnt_c;
  int               srch;

  // Unpacked per-requester command fields.
  logic [AW-1:0]    addr_a  [NREQ];
  logic [WIDTH-1:0] wdata_a [NREQ];

  // RAM command register.
  logic             ram_we_q;
  logic [AW-1:0]    ram_addr_q;
  logic [WIDTH-1:0] ram_data_q;

  // Read tag pipeline: stage 1 aligns with the RAM address register,
  // stage 2 with the RAM output register, rvalid_q with valid ram_q.
  logic             tag1_v_q, tag2_v_q;
  logic [IDW-1:0]   tag1_id_q, tag2_id_q;
  logic [NREQ-1:0]  rvalid_q, rvalid_d;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_a[gi]  = bus.req_addr[gi*AW +: AW];
      assign wdata_a[gi] = bus.req_wdata[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Search req upward from the pointer, wrapping; the first set bit wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    srch      = 0;
    for (int k = 0; k < NREQ; k++) begin
      srch = int'(ptr_q) + k;
      if (srch >= NREQ) srch = srch - NREQ;
      if (!win_found && bus.req[srch[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = srch[IDW-1:0];
      end
    end
  end

  // No grant can be issued while reset is asserted.
  assign grant_v = win_found & rst_n;
  assign win_inc = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);

  // One-hot grant decode.
  always_comb begin
    gnt_c = '0;
    if (grant_v) gnt_c[win_id] = 1'b1;
  end

  assign bus.gnt = gnt_c;

`ifdef ARB_LOCK_EN
  localparam int LCW = $clog2(LOCK_MAX + 1);

  logic [LCW-1:0] lock_cnt_q, lock_cnt_d, lock_cnt_nx;
  logic [IDW-1:0] lock_id_q, lock_id_d;

  // Locked winners keep the pointer until they run LOCK_MAX grants in a row;
  // an unlocked grant or a grant to someone else restarts the count.
  always_comb begin
    ptr_d       = ptr_q;
    lock_cnt_d  = lock_cnt_q;
    lock_id_d   = lock_id_q;
    lock_cnt_nx = LCW'(1);
    if (grant_v) begin
      if (bus.req_lock[win_id]) begin
        if (lock_cnt_q != '0 && lock_id_q == win_id) begin
          lock_cnt_nx = lock_cnt_q + LCW'(1);
        end
        if (lock_cnt_nx >= LCW'(LOCK_MAX)) begin
          ptr_d      = win_inc;
          lock_cnt_d = '0;
        end else begin
          ptr_d      = win_id;
          lock_cnt_d = lock_cnt_nx;
        end
        lock_id_d = win_id;
      end else begin
        ptr_d      = win_inc;
        lock_cnt_d = '0;
      end
    end
  end

  // Lock run bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
      lock_id_q  <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_id_q  <= lock_id_d;
    end
  end
`else
  // Plain round-robin: move past the winner, hold when idle.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_v) ptr_d = win_inc;
  end
`endif

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Register the winning command onto the RAM port; idle cycles drop the
  // write enable but keep address/data so the RAM sees no spurious change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else if (grant_v) begin
      ram_we_q   <= bus.req_we[win_id];
      ram_addr_q <= addr_a[win_id];
      ram_data_q <= wdata_a[win_id];
    end else begin
      ram_we_q   <= 1'b0;
    end
  end

  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_data_o = ram_data_q;

  // Advance read tags alongside the RAM's two internal register stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_v_q  <= 1'b0;
      tag1_id_q <= '0;
      tag2_v_q  <= 1'b0;
      tag2_id_q <= '0;
    end else begin
      tag1_v_q  <= grant_v & ~bus.req_we[win_id];
      tag1_id_q <= win_id;
      tag2_v_q  <= tag1_v_q;
      tag2_id_q <= tag1_id_q;
    end
  end

  // Decode the last tag stage into the one-hot return strobe.
  always_comb begin
    rvalid_d = '0;
    if (tag2_v_q) rvalid_d[tag2_id_q] = 1'b1;
  end

  // Register the return strobe so it lines up with the RAM output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid_q <= '0;
    else        rvalid_q <= rvalid_d;
  end

  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = ram_q_i;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: self-checking bench for ram_port_arbiter with a
// behavioural single-port RAM (registered address, registered output).
// Reference model: grants are commands executed in order against an abstract
// memory array; each read produces an expected return three cycles later.
module tb_ram_port_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int NREQ  = 4;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) bus();

  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_data;
  logic [WIDTH-1:0] ram_q;

  ram_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .LOCK_MAX(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_we_o  (ram_we),
    .ram_addr_o(ram_addr),
    .ram_data_o(ram_data),
    .ram_q_i   (ram_q)
  );

  // Behavioural RAM instance sitting next to the arbiter.
  logic [WIDTH-1:0] ram_mem [DEPTH];
  logic [AW-1:0]    ram_addr_r;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_addr_r <= ram_addr;
    ram_q      <= ram_mem[ram_addr_r];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct {
    int               due;
    int               id;
    logic [WIDTH-1:0] data;
  } ret_t;

  int               m_ptr = 0;
  logic [WIDTH-1:0] m_mem [DEPTH];
  ret_t             exp_q[$];

  int               n_tests = 0;
  int               n_fail  = 0;
  int               w;
  logic [NREQ-1:0]  egnt, erv;
  logic [WIDTH-1:0] erd;

  function automatic int exp_winner(logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_accept(int wi);
    logic [AW-1:0] a;
    ret_t e;
    a = bus.req_addr[wi*AW +: AW];
    if (bus.req_we[wi]) begin
      m_mem[a] = bus.req_wdata[wi*WIDTH +: WIDTH];
      $display("[TB] cyc=%0d grant req%0d WR addr=%0d data=%h", cyc, wi, a, m_mem[a]);
    end else begin
      e.due = cyc + 3; e.id = wi; e.data = m_mem[a];
      exp_q.push_back(e);
      $display("[TB] cyc=%0d grant req%0d RD addr=%0d expect=%h", cyc, wi, a, e.data);
    end
    m_ptr = (wi + 1) % NREQ;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    exp_q.delete();
  endtask

  task automatic pop_expect(output logic [NREQ-1:0] rv, output logic [WIDTH-1:0] rd);
    rv = '0; rd = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      rv = NREQ'(1 << exp_q[0].id);
      rd = exp_q[0].data;
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_all();
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
  endtask

  task automatic drive(int i, bit r, bit we, int addr, int data);
    bus.req[i] = r;
    bus.req_we[i] = we;
    bus.req_addr[i*AW +: AW] = AW'(addr);
    bus.req_wdata[i*WIDTH +: WIDTH] = WIDTH'(data);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_all();
    #2 rst_n = 1'b0;
    bus.req = '1;
    for (int st = 0; st < 2; st++) begin
      @(negedge clk);
      n_tests++;
      if (bus.gnt !== '0 || bus.rvalid !== '0) begin
        n_fail++; $display("FAIL reset_grant gnt=%b rvalid=%b required 0000/0000", bus.gnt, bus.rvalid);
      end
      n_tests++;
      if (ram_we !== 1'b0 || ram_addr !== '0 || ram_data !== '0) begin
        n_fail++; $display("FAIL reset_ram we=%b addr=%0d data=%h required 0/0/00", ram_we, ram_addr, ram_data);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_all();
    model_reset();
  endtask

  task automatic test_basic();
    for (int st = 0; st < 5; st++) begin
      idle_all();
      if (st == 0) drive(0, 1, 1, 5, 'hA5);
      if (st == 1) drive(0, 1, 0, 5, 0);
      @(negedge clk);
      w = rst_n ? exp_winner(bus.req) : -1;
      egnt = (w < 0) ? '0 : NREQ'(1 << w);
      pop_expect(erv, erd);
      n_tests++;
      if (bus.gnt !== egnt) begin n_fail++; $display("FAIL basic_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, egnt); end
      n_tests++;
      if (bus.rvalid !== erv || (erv != '0 && bus.rdata !== erd)) begin
        n_fail++; $display("FAIL basic_ret cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.rvalid, bus.rdata, erv, erd);
      end
      if (st == 1) begin
        n_tests++;
        if (ram_we !== 1'b1 || ram_addr !== AW'(5) || ram_data !== 8'hA5) begin
          n_fail++; $display("FAIL basic_ramcmd we=%b addr=%0d data=%h required 1/5/a5", ram_we, ram_addr, ram_data);
        end
      end
      if (st == 4) begin
        n_tests++;
        if (bus.rvalid !== 4'b0001 || bus.rdata !== 8'hA5) begin
          n_fail++; $display("FAIL basic_readback got=%b/%h required 0001/a5", bus.rvalid, bus.rdata);
        end
      end
      if (w >= 0) model_accept(w);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_preload();
    for (int st = 0; st < DEPTH + 3; st++) begin
      idle_all();
      if (st < DEPTH) drive(0, 1, 1, st, st);
      @(negedge clk);
      w = rst_n ? exp_winner(bus.req) : -1;
      egnt = (w < 0) ? '0 : NREQ'(1 << w);
      pop_expect(erv, erd);
      n_tests++;
      if (bus.gnt !== egnt || bus.rvalid !== erv) begin
        n_fail++; $display("FAIL preload cyc=%0d gnt=%b/%b rvalid=%b/%b (got/exp)", cyc, bus.gnt, egnt, bus.rvalid, erv);
      end
      if (w >= 0) model_accept(w);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rotation();
    int next_addr;
    apply_reset();
    idle_all();
    for (int i = 0; i < NREQ; i++) drive(i, 1, 0, 20 + i, 0);
    next_addr = 24;
    for (int st = 0; st < 11; st++) begin
      @(negedge clk);
      w = rst_n ? exp_winner(bus.req) : -1;
      egnt = (w < 0) ? '0 : NREQ'(1 << w);
      pop_expect(erv, erd);
      n_tests++;
      if (bus.gnt !== egnt) begin n_fail++; $display("FAIL rot_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, egnt); end
      n_tests++;
      if (bus.rvalid !== erv || (erv != '0 && bus.rdata !== erd)) begin
        n_fail++; $display("FAIL rot_ret cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.rvalid, bus.rdata, erv, erd);
      end
      if (st < 8) begin
        n_tests++;
        if (bus.gnt !== NREQ'(1 << (st % NREQ))) begin
          n_fail++; $display("FAIL rot_order step=%0d got=%b required %b", st, bus.gnt, NREQ'(1 << (st % NREQ)));
        end
      end
      if (st >= 3) begin
        n_tests++;
        if (bus.rvalid !== NREQ'(1 << ((st - 3) % NREQ)) || bus.rdata !== WIDTH'(17 + st)) begin
          n_fail++; $display("FAIL rot_data step=%0d got=%b/%h required %b/%h", st, bus.rvalid, bus.rdata,
                             NREQ'(1 << ((st - 3) % NREQ)), WIDTH'(17 + st));
        end
      end
      if (w >= 0) model_accept(w);
      @(posedge clk); #1;
      if (w >= 0) begin
        if (st < 7) begin drive(w, 1, 0, next_addr, 0); next_addr++; end
        else drive(w, 0, 0, 0, 0);
      end
    end
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] want [3];
    want[0] = 4'b0010; want[1] = 4'b0001; want[2] = 4'b0010;
    apply_reset();
    for (int st = 0; st < 6; st++) begin
      idle_all();
      if (st == 0) drive(1, 1, 0, 7, 0);
      if (st == 1) begin drive(0, 1, 0, 8, 0); drive(1, 1, 0, 9, 0); end
      if (st == 2) drive(1, 1, 0, 9, 0);
      @(negedge clk);
      w = rst_n ? exp_winner(bus.req) : -1;
      egnt = (w < 0) ? '0 : NREQ'(1 << w);
      pop_expect(erv, erd);
      n_tests++;
      if (bus.gnt !== egnt) begin n_fail++; $display("FAIL wrap_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, egnt); end
      n_tests++;
      if (bus.rvalid !== erv || (erv != '0 && bus.rdata !== erd)) begin
        n_fail++; $display("FAIL wrap_ret cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.rvalid, bus.rdata, erv, erd);
      end
      if (st < 3) begin
        n_tests++;
        if (bus.gnt !== want[st]) begin n_fail++; $display("FAIL wrap_order step=%0d got=%b required %b", st, bus.gnt, want[st]); end
      end
      if (w >= 0) model_accept(w);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hazard();
    for (int st = 0; st < 5; st++) begin
      idle_all();
      if (st == 0) drive(2, 1, 1, 63, 'h3C);
      if (st == 1) drive(3, 1, 0, 63, 0);
      @(negedge clk);
      w = rst_n ? exp_winner(bus.req) : -1;
      egnt = (w < 0) ? '0 : NREQ'(1 << w);
      pop_expect(erv, erd);
      n_tests++;
      if (bus.gnt !== egnt) begin n_fail++; $display("FAIL hazard_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, egnt); end
      n_tests++;
      if (bus.rvalid !== erv || (erv != '0 && bus.rdata !== erd)) begin
        n_fail++; $display("FAIL hazard_ret cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.rvalid, bus.rdata, erv, erd);
      end
      if (st == 4) begin
        n_tests++;
        if (bus.rvalid !== 4'b1000 || bus.rdata !== 8'h3C) begin
          n_fail++; $display("FAIL hazard_data got=%b/%h required 1000/3c", bus.rvalid, bus.rdata);
        end
      end
      if (w >= 0) model_accept(w);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midread();
    idle_all();
    drive(0, 1, 0, 9, 0);
    for (int st = 0; st < 7; st++) begin
      if (st == 1) begin rst_n = 1'b0; bus.req = '1; model_reset(); end
      if (st == 2) begin rst_n = 1'b1; idle_all(); end
      @(negedge clk);
      w = rst_n ? exp_winner(bus.req) : -1;
      egnt = (w < 0) ? '0 : NREQ'(1 << w);
      pop_expect(erv, erd);
      n_tests++;
      if (bus.gnt !== egnt) begin n_fail++; $display("FAIL midrst_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, egnt); end
      n_tests++;
      if (bus.rvalid !== erv) begin n_fail++; $display("FAIL midrst_rvalid cyc=%0d got=%b exp=%b", cyc, bus.rvalid, erv); end
      if (st == 1) begin
        n_tests++;
        if (ram_we !== 1'b0 || ram_addr !== '0 || ram_data !== '0) begin
          n_fail++; $display("FAIL midrst_ram we=%b addr=%0d data=%h required 0/0/00", ram_we, ram_addr, ram_data);
        end
      end
      if (w >= 0) model_accept(w);
      @(posedge clk); #1;
      if (st == 0) drive(0, 0, 0, 0, 0);
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [NREQ-1:0] want;
    apply_reset();
    idle_all();
    bus.req_lock = 4'b0001;
    drive(0, 1, 0, 1, 0);
    drive(1, 1, 0, 2, 0);
    for (int st = 0; st < 10; st++) begin
      want = (st == 8) ? 4'b0010 : 4'b0001;
      @(negedge clk);
      n_tests++;
      if (bus.gnt !== want) begin n_fail++; $display("FAIL lock_gnt step=%0d got=%b required %b", st, bus.gnt, want); end
      @(posedge clk); #1;
    end
    idle_all();
    bus.req_lock = '0;
    for (int st = 0; st < 4; st++) begin @(posedge clk); #1; end
    apply_reset();
  endtask
`endif

  task automatic test_random();
    for (int st = 0; st < 310; st++) begin
      if (st < 300) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!bus.req[i] && $urandom_range(0, 9) < 6)
            drive(i, 1, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
        end
      end
      @(negedge clk);
      w = rst_n ? exp_winner(bus.req) : -1;
      egnt = (w < 0) ? '0 : NREQ'(1 << w);
      pop_expect(erv, erd);
      n_tests++;
      if (bus.gnt !== egnt) begin n_fail++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, egnt); end
      n_tests++;
      if (bus.rvalid !== erv || (erv != '0 && bus.rdata !== erd)) begin
        n_fail++; $display("FAIL rand_ret cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.rvalid, bus.rdata, erv, erd);
      end
      if (w >= 0) model_accept(w);
      @(posedge clk); #1;
      if (w >= 0) bus.req[w] = 1'b0;
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain pending=%0d required 0", exp_q.size()); end
  endtask

  initial begin
    idle_all();
`ifdef ARB_LOCK_EN
    bus.req_lock = '0;
`endif
    test_reset();
    test_basic();
    test_preload();
    test_rotation();
    test_wrap();
    test_hazard();
    test_reset_midread();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
